sram_bank_ctrl: RTL
===================

SRAM_BANK_CTRL -- requirements
Module: sram_bank_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 4, width of a data word.
REQ-002 SHALL have parameter ADDR_W, default 8, address width; depth is 2**ADDR_W words.
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal range 1..4.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 1, request present.
REQ-007 SHALL have port req_ready, output, 1, controller accepts a request this cycle.
REQ-008 SHALL have port wr_rd_en, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have port addr, input, ADDR_W, word address.
REQ-010 SHALL have port data_in, input, DATA_W, write data.
REQ-011 SHALL have port rsp_valid, output, 1, read data valid on data_out.
REQ-012 SHALL have port data_out, output, DATA_W, read data.
REQ-013 SHALL have port init_done, output, 1, memory clear sweep complete.

Function
REQ-014 SHALL implement FSM states INIT and READY; reset forces INIT with sweep counter 0.
REQ-015 In INIT: SHALL write 0 to one address per cycle, 0 up to 2**ADDR_W-1, then move to READY; sweep takes exactly 2**ADDR_W cycles.
REQ-016 init_done SHALL be 0 in INIT and 1 in READY; req_ready SHALL equal init_done.
REQ-017 Request accepted iff req_valid and req_ready on a rising edge; requests in INIT are ignored, never queued.
REQ-018 Accepted write SHALL update the word at the accepting edge and produce no response.
REQ-019 Accepted read SHALL drive rsp_valid high for exactly one cycle, RD_LAT cycles after the accepting edge, with the addressed word on data_out.
REQ-020 SHALL sustain one accepted request per cycle; back-to-back reads return in order, one per cycle.
REQ-021 Write followed by read of same address on the next cycle SHALL return the newly written data.
REQ-022 data_out SHALL hold the last returned read value while rsp_valid is 0.
REQ-023 Every address reachable; no out-of-range case exists.

Reset
REQ-024 On reset: rsp_valid=0, data_out=0, req_ready=0, init_done=0 from the next edge.
REQ-025 Reset mid-sweep or with reads in flight SHALL discard all pending responses and restart the sweep at address 0.
REQ-026 data_out SHALL remain 0 from the first edge after reset asserts until the first read response after reset.

Configuration
REQ-027 Macro SRAM_PARITY_EN SHALL add even parity storage: one extra stored bit per word, output parity_err (1 bit), input inj_par_err (1 bit).
REQ-028 With SRAM_PARITY_EN: write stores inverted parity if inj_par_err=1; parity_err pulses with rsp_valid on mismatch; sweep stores correct parity; parity_err resets to 0.
REQ-029 Without SRAM_PARITY_EN: no parity_err/inj_par_err ports, storage exactly DATA_W bits wide, behaviour otherwise identical.

Structure
REQ-030 Package sram_pkg SHALL hold the FSM state enum, default parameter constants and the RD_LAT range limits.
REQ-031 Storage SHALL be sub-module sram_array (single write port, synchronous read, parameterised width/depth); control and latency pipeline live in sram_bank_ctrl.

Verification
REQ-032 Reset 3 cycles, release -> init_done=0 for 256 cycles, then 1; read addr 0x55 -> data_out=0x0.
REQ-033 RD_LAT=3: write 0xA to 0x10, read 0x10 next cycle -> rsp_valid exactly 3 cycles later, data_out=0xA.
REQ-034 Reads of 0x01,0x02,0x03 on consecutive cycles after writing 0x1,0x2,0x3 -> three consecutive rsp_valid pulses, data 0x1,0x2,0x3.
REQ-035 Reset asserted with 2 reads in flight -> no rsp_valid, data_out=0, sweep restarts (init_done=0 for 256 cycles).
REQ-036 req_valid=1 write 0xF to 0x20 during INIT -> ignored; read 0x20 after init -> 0x0.
REQ-037 SRAM_PARITY_EN: write 0x5 to 0x30 with inj_par_err=1, read 0x30 -> parity_err=1 with rsp_valid, data_out=0x5.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM bank controller slice.
// SRAM_PARITY_EN (optional) adds one stored even-parity bit per word.
package sram_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 8;
  localparam int RD_LAT_DEF = 1;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Even parity over a zero-extended word; callers cast their data to 64 bits.
  function automatic logic even_par(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sram_array.sv
// Single-write-port storage with a registered (synchronous) read port.
module sram_array #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_r [0:(2**ADDR_W)-1];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read port, registered every cycle; the controller qualifies it with its own valid
  always_ff @(posedge clk) begin
    rdata <= mem_r[raddr];
  end

endmodule

// File: rtl/sram_bank_ctrl.sv
// SRAM bank controller: clears memory after reset, then serves one request per cycle.
// Build option: define SRAM_PARITY_EN for per-word parity with error injection.
module sram_bank_ctrl
  import sram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              wr_rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              init_done
`ifdef SRAM_PARITY_EN
  ,
  output logic              parity_err,
  input  logic              inj_par_err
`endif
);

  // Out-of-range latencies are pulled into the supported window.
  localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                       (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
`ifdef SRAM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  state_e              state_r;
  logic [ADDR_W-1:0]   sweep_cnt_r;
  logic                init_done_r;
  logic                acc_s;
  logic                acc_rd_s;
  logic                acc_wr_s;
  logic                arr_we_s;
  logic [ADDR_W-1:0]   arr_waddr_s;
  logic [WORD_W-1:0]   arr_wdata_s;
  logic [WORD_W-1:0]   arr_rdata_s;
  logic [LAT-1:0]      vld_r;
  logic [WORD_W-1:0]   tail_dat_s;
  logic                rsp_valid_r;
  logic [DATA_W-1:0]   data_out_r;
  logic                par_err_r;

  assign acc_s    = req_valid & init_done_r & ~reset;
  assign acc_rd_s = acc_s & ~wr_rd_en;
  assign acc_wr_s = acc_s & wr_rd_en;

  // Write-port mux: the clear sweep owns the port in INIT, accepted writes in READY
  always_comb begin
    arr_we_s    = 1'b0;
    arr_waddr_s = sweep_cnt_r;
    arr_wdata_s = {WORD_W{1'b0}};
    if ((state_r == ST_INIT) && !reset) begin
      arr_we_s    = 1'b1;
      arr_waddr_s = sweep_cnt_r;
      arr_wdata_s = {WORD_W{1'b0}};
    end else if (acc_wr_s) begin
      arr_we_s    = 1'b1;
      arr_waddr_s = addr;
`ifdef SRAM_PARITY_EN
      arr_wdata_s = {even_par(64'(data_in)) ^ inj_par_err, data_in};
`else
      arr_wdata_s = data_in;
`endif
    end else begin
      arr_we_s = 1'b0;
    end
  end

  sram_array #(
    .WIDTH  (WORD_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we_s),
    .waddr (arr_waddr_s),
    .wdata (arr_wdata_s),
    .raddr (addr),
    .rdata (arr_rdata_s)
  );

  // Control FSM: one cleared address per cycle, then READY until the next reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_INIT;
      sweep_cnt_r <= {ADDR_W{1'b0}};
      init_done_r <= 1'b0;
    end else begin
      case (state_r)
        ST_INIT: begin
          sweep_cnt_r <= sweep_cnt_r + ADDR_W'(1);
          if (sweep_cnt_r == {ADDR_W{1'b1}}) begin
            state_r     <= ST_READY;
            init_done_r <= 1'b1;
          end else begin
            state_r     <= ST_INIT;
            init_done_r <= 1'b0;
          end
        end
        ST_READY: begin
          state_r     <= ST_READY;
          init_done_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_INIT;
          sweep_cnt_r <= {ADDR_W{1'b0}};
          init_done_r <= 1'b0;
        end
      endcase
    end
  end

  // Read-valid pipeline; stage 0 lines up with the array's registered read data
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_r <= {LAT{1'b0}};
    end else begin
      vld_r[0] <= acc_rd_s;
      for (int k = 1; k < LAT; k++) begin
        vld_r[k] <= vld_r[k-1];
      end
    end
  end

  if (LAT == 1) begin : g_lat1
    assign tail_dat_s = arr_rdata_s;
  end else begin : g_latn
    logic [LAT-2:0][WORD_W-1:0] dat_r;

    // Extra data stages; contents only matter where the matching valid bit is set
    always_ff @(posedge clk) begin
      dat_r[0] <= arr_rdata_s;
      for (int k = 1; k < LAT - 1; k++) begin
        dat_r[k] <= dat_r[k-1];
      end
    end

    assign tail_dat_s = dat_r[LAT-2];
  end

  // Response registers; data_out keeps the last returned word between responses
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_r <= 1'b0;
      data_out_r  <= {DATA_W{1'b0}};
      par_err_r   <= 1'b0;
    end else begin
      rsp_valid_r <= vld_r[LAT-1];
      if (vld_r[LAT-1]) begin
        data_out_r <= tail_dat_s[DATA_W-1:0];
        par_err_r  <= even_par(64'(tail_dat_s[DATA_W-1:0])) != tail_dat_s[WORD_W-1];
      end else begin
        par_err_r  <= 1'b0;
      end
    end
  end

  assign req_ready = init_done_r;
  assign init_done = init_done_r;
  assign rsp_valid = rsp_valid_r;
  assign data_out  = data_out_r;
`ifdef SRAM_PARITY_EN
  assign parity_err = par_err_r;
`endif

endmodule
